nexus_pifo_scheduler: RTL and testbench

NEXUS_PIFO_SCHEDULER -- requirements
Module: nexus_pifo_scheduler

---
 rtl/nexus_pifo_pkg.sv | 19 +
 rtl/nexus_rr_arbiter.sv | 30 +++
 rtl/nexus_pifo_scheduler.sv | 142 ++++++++++++++
 tb/tb_nexus_pifo_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexus_pifo_pkg.sv
// Shared widths, entry layout and scheduler state encoding for the PIFO scheduler.
package nexus_pifo_pkg;

  localparam int unsigned PTW_DEF = 16;
  localparam int unsigned MTW_DEF = 32;
  localparam int unsigned EW_DEF  = MTW_DEF + PTW_DEF;

  // Priority sits in the low bits; lower value wins.
  typedef struct packed {
    logic [MTW_DEF-1:0] meta;
    logic [PTW_DEF-1:0] prio;
  } entry_t;

  typedef enum logic {
    S_PUSH = 1'b0,
    S_POP  = 1'b1
  } state_e;

endpackage

// File: rtl/nexus_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module nexus_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_any_c
);

  always_comb begin
    int unsigned k;
    k         = 0;
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = i + 32'(i_ptr);
      if (k >= N) k = k - N;
      if (!o_any_c && i_req[k]) begin
        o_any_c      = 1'b1;
        o_grant_c[k] = 1'b1;
        o_idx_c      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/nexus_pifo_scheduler.sv
// Push/pop scheduler in front of a PIFO micro sorter with anti-starvation of pops.
// Optional statistics counters are enabled with NEXUS_SCHED_STATS_EN.
module nexus_pifo_scheduler
  import nexus_pifo_pkg::*;
#(
  parameter  int unsigned NREQ   = 4,
  parameter  int unsigned PTW    = PTW_DEF,
  parameter  int unsigned MTW    = MTW_DEF,
  parameter  int unsigned STARVE = 8,
  localparam int unsigned EW     = MTW + PTW
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*EW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_deq_valid,
  output logic [EW-1:0]      o_deq_data,
  input  logic               i_deq_ready,
  output logic               o_srt_push,
  output logic [EW-1:0]      o_srt_push_data,
  output logic               o_srt_pop,
  input  logic [EW-1:0]      i_srt_pop_data,
  input  logic               i_srt_full,
  input  logic               i_srt_empty
`ifdef NEXUS_SCHED_STATS_EN
  ,
  output logic [31:0]        o_push_cnt,
  output logic [31:0]        o_pop_cnt
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = (STARVE > 1) ? $clog2(STARVE) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [SW-1:0]   r_streak;
  logic [SW-1:0]   w_streak_nxt;
  logic            r_deq_valid;
  logic [EW-1:0]   r_deq_data;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_win;
  logic            w_any;
  logic            w_push_elig;
  logic            w_pop_elig;
  logic            w_starve_hit;
  logic            w_push;
  logic            w_pop;

  nexus_rr_arbiter #(.N(NREQ)) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_win),
    .o_any_c   (w_any)
  );

  // Eligibility is masked by reset so nothing is issued while it is held.
  assign w_push_elig  = !i_arst && w_any && !i_srt_full;
  assign w_pop_elig   = !i_arst && !i_srt_empty && (!r_deq_valid || i_deq_ready);
  assign w_starve_hit = (r_streak == SW'(STARVE - 1));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_PUSH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_PUSH;
    if (r_state == S_PUSH && w_push && w_pop_elig && w_starve_hit) w_state_nxt = S_POP;
  end

  always_comb begin
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_streak_nxt = '0;
    unique case (r_state)
      S_PUSH: begin
        w_push = w_push_elig;
        w_pop  = !w_push_elig && w_pop_elig;
        if (w_push && w_pop_elig) w_streak_nxt = w_starve_hit ? '0 : r_streak + SW'(1);
      end
      S_POP: begin
        w_pop  = w_pop_elig;
        w_push = !w_pop_elig && w_push_elig;
      end
      default: ;
    endcase
  end

  assign o_srt_push      = w_push;
  assign o_srt_pop       = w_pop;
  assign o_req_ready     = w_push ? w_grant : '0;
  assign o_srt_push_data = i_req_data[32'(w_win)*EW +: EW];

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_rr_ptr <= '0;
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
      if (w_push) r_rr_ptr <= (32'(w_win) == NREQ - 1) ? '0 : w_win + IW'(1);
    end
  end

  // Output stage: a pop refills in the same edge as a consumer handshake.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_deq_valid <= 1'b0;
      r_deq_data  <= '1;
    end else if (w_pop) begin
      r_deq_valid <= 1'b1;
      r_deq_data  <= i_srt_pop_data;
    end else if (i_deq_ready) begin
      r_deq_valid <= 1'b0;
    end
  end

  assign o_deq_valid = r_deq_valid;
  assign o_deq_data  = r_deq_data;

`ifdef NEXUS_SCHED_STATS_EN
  logic [31:0] r_push_cnt;
  logic [31:0] r_pop_cnt;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
    end else begin
      if (w_push) r_push_cnt <= r_push_cnt + 32'd1;
      if (w_pop)  r_pop_cnt  <= r_pop_cnt + 32'd1;
    end
  end

  assign o_push_cnt = r_push_cnt;
  assign o_pop_cnt  = r_pop_cnt;
`endif

endmodule

// File: tb/tb_nexus_pifo_scheduler.sv
// Self-checking bench: behavioural scheduler model plus a queue-based sorter stand-in.
module tb_nexus_pifo_scheduler;
  localparam int NREQ   = 4;
  localparam int EW     = 48;
  localparam int STARVE = 8;

  logic             clk = 1'b0;
  logic             arst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*EW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             deq_valid;
  logic [EW-1:0]    deq_data;
  logic             deq_ready;
  logic             srt_push;
  logic [EW-1:0]    srt_push_data;
  logic             srt_pop;
  logic [EW-1:0]    srt_pop_data;
  logic             srt_full;
  logic             srt_empty;
`ifdef NEXUS_SCHED_STATS_EN
  logic [31:0]      push_cnt;
  logic [31:0]      pop_cnt;
`endif

  nexus_pifo_scheduler #(.NREQ(NREQ), .PTW(16), .MTW(32), .STARVE(STARVE)) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .o_req_ready     (req_ready),
    .o_deq_valid     (deq_valid),
    .o_deq_data      (deq_data),
    .i_deq_ready     (deq_ready),
    .o_srt_push      (srt_push),
    .o_srt_push_data (srt_push_data),
    .o_srt_pop       (srt_pop),
    .i_srt_pop_data  (srt_pop_data),
    .i_srt_full      (srt_full),
    .i_srt_empty     (srt_empty)
`ifdef NEXUS_SCHED_STATS_EN
    ,
    .o_push_cnt      (push_cnt),
    .o_pop_cnt       (pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus state and sorter stand-in (sorted by priority, FIFO among ties).
  logic [EW-1:0] rd [NREQ];
  logic [NREQ-1:0] rv;
  logic          dr;
  logic [EW-1:0] sq [$];
  int            cap;

  // Reference model state.
  int            m_rr;
  int            m_run;
  bit            m_starved;
  bit            m_ov;
  logic [EW-1:0] m_od;
  logic [31:0]   m_pushes;
  logic [31:0]   m_pops;

  int total, bad;
  int t_cyc;
  bit          t_push [64];
  bit          t_pop  [64];
  bit          t_ov   [64];
  logic [3:0]  t_rdy  [64];
  logic [15:0] t_op   [64];
  bit last_push;
  int last_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [15:0] p);
    return {32'($urandom), p};
  endfunction

  task automatic drive_inputs();
    req_valid = rv;
    for (int k = 0; k < NREQ; k++) req_data[k*EW +: EW] = rd[k];
    deq_ready    = dr;
    srt_full     = (sq.size() >= cap);
    srt_empty    = (sq.size() == 0);
    srt_pop_data = (sq.size() == 0) ? '1 : sq[0];
  endtask

  task automatic model_reset();
    m_rr = 0; m_run = 0; m_starved = 0; m_ov = 0; m_od = '1;
    m_pushes = 0; m_pops = 0;
    sq.delete();
  endtask

  // One clock: drive at negedge, compare after settling, advance model and sorter.
  task automatic step();
    bit pe, qe, eu, ep, found;
    int w, pos;
    logic [EW-1:0] e;
    drive_inputs();
    #1;
    pe = (rv != 0) && (sq.size() < cap);
    qe = (sq.size() != 0) && (!m_ov || dr);
    if (m_starved) begin ep = qe; eu = !qe && pe; end
    else           begin eu = pe; ep = !pe && qe; end
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_rr + i) % NREQ;
      if (w < 0 && rv[k]) w = k;
    end
    chk("push", 64'(srt_push), 64'(eu));
    chk("pop", 64'(srt_pop), 64'(ep));
    chk("req_ready", 64'(req_ready), eu ? 64'(1 << w) : 64'd0);
    if (eu) chk("push_data", 64'(srt_push_data), 64'(rd[w]));
    chk("deq_valid", 64'(deq_valid), 64'(m_ov));
    chk("deq_data", 64'(deq_data), 64'(m_od));
`ifdef NEXUS_SCHED_STATS_EN
    chk("push_cnt", 64'(push_cnt), 64'(m_pushes));
    chk("pop_cnt", 64'(pop_cnt), 64'(m_pops));
`endif
    if (t_cyc < 64) begin
      t_push[t_cyc] = srt_push; t_pop[t_cyc] = srt_pop; t_ov[t_cyc] = deq_valid;
      t_rdy[t_cyc] = req_ready; t_op[t_cyc] = deq_data[15:0];
    end
    t_cyc++;
    if (m_starved) begin m_starved = 0; m_run = 0; end
    else if (eu && qe) begin
      m_run++;
      if (m_run == STARVE) begin m_starved = 1; m_run = 0; end
    end else m_run = 0;
    if (ep) begin m_ov = 1; m_od = sq[0]; end
    else if (dr) m_ov = 0;
    if (ep) begin sq.pop_front(); m_pops++; end
    if (eu) begin
      e = rd[w]; pos = sq.size(); found = 0;
      for (int i = 0; i < sq.size(); i++)
        if (!found && sq[i][15:0] > e[15:0]) begin pos = i; found = 1; end
      sq.insert(pos, e);
      m_rr = (w + 1) % NREQ;
      m_pushes++;
    end
    last_push = eu;
    last_w = w;
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    arst = 1'b1; rv = '1; dr = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      drive_inputs();
      #1;
      chk("rst_deq_valid", 64'(deq_valid), 64'd0);
      chk("rst_deq_data", 64'(deq_data), 64'hFFFF_FFFF_FFFF);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_push", 64'(srt_push), 64'd0);
      chk("rst_pop", 64'(srt_pop), 64'd0);
      @(negedge clk);
    end
    arst = 1'b0; rv = '0; dr = 1'b0;
    model_reset();
    t_cyc = 0;
  endtask

  task automatic rand_req();
    for (int k = 0; k < NREQ; k++) begin
      if (rv[k]) begin
        if (last_push && last_w == k) begin
          rv[k] = 1'($urandom_range(0, 1));
          rd[k] = mk(16'($urandom_range(0, 31)));
        end else if ($urandom_range(0, 15) == 0) rv[k] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rv[k] = 1'b1;
        rd[k] = mk(16'($urandom_range(0, 31)));
      end
    end
    dr = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    total = 0; bad = 0; t_cyc = 0; cap = 8;
    arst = 1'b1; rv = '0; dr = 1'b0;
    for (int k = 0; k < NREQ; k++) rd[k] = '0;
    model_reset();
    drive_inputs();
    @(negedge clk);
    do_reset(2);

    // Single push from requester 2 into an empty sorter.
    rd[2] = {32'hA5A5_0002, 16'd5}; rv = 4'b0100; dr = 1'b1;
    for (int c = 0; c < 3; c++) begin step(); if (last_push) rv[last_w] = 1'b0; end
    chk("t1_push0", 64'(t_push[0]), 64'd1);
    chk("t1_ready0", 64'(t_rdy[0]), 64'h4);
    chk("t1_pop1", 64'(t_pop[1]), 64'd1);
    chk("t1_valid1", 64'(t_ov[1]), 64'd0);
    chk("t1_valid2", 64'(t_ov[2]), 64'd1);
    chk("t1_prio2", 64'(t_op[2]), 64'd5);

    // All requesters valid, consumer stalled, sorter of depth 4.
    do_reset(1);
    cap = 4; rv = 4'hF; dr = 1'b0;
    for (int k = 0; k < NREQ; k++) rd[k] = mk(16'(10 + k));
    for (int c = 0; c < 7; c++) begin step(); if (last_push) rd[last_w] = mk(16'(20 + c)); end
    chk("t2_grant0", 64'(t_rdy[0]), 64'h1);
    chk("t2_grant1", 64'(t_rdy[1]), 64'h2);
    chk("t2_grant2", 64'(t_rdy[2]), 64'h4);
    chk("t2_grant3", 64'(t_rdy[3]), 64'h8);
    chk("t2_pop4", 64'(t_pop[4]), 64'd1);
    chk("t2_grant5", 64'(t_rdy[5]), 64'h1);
    chk("t2_full_push6", 64'(t_push[6]), 64'd0);
    chk("t2_full_ready6", 64'(t_rdy[6]), 64'd0);
    chk("t2_full_pop6", 64'(t_pop[6]), 64'd0);

    // Starvation guard: one pop after every STARVE pushes.
    do_reset(1);
    cap = 64; rv = 4'hF; dr = 1'b1;
    for (int c = 0; c < 30; c++) begin step(); if (last_push) rd[last_w] = mk(16'(c)); end
    for (int c = 0; c < 30; c++) begin
      bit ep;
      ep = (c == 9 || c == 18 || c == 27);
      chk("t3_pop", 64'(t_pop[c]), 64'(ep));
      chk("t3_push", 64'(t_push[c]), 64'(!ep));
    end

    // Priority order on drain, then stall hold, then drain of the rest.
    do_reset(1);
    cap = 8; dr = 1'b1; rv = 4'b0111;
    rd[0] = mk(16'd9); rd[1] = mk(16'd3); rd[2] = mk(16'd7);
    for (int c = 0; c < 6; c++) begin step(); if (last_push) rv[last_w] = 1'b0; end
    dr = 1'b0; rv = 4'b0011; rd[0] = mk(16'd20); rd[1] = mk(16'd21);
    for (int c = 0; c < 2; c++) begin step(); if (last_push) rv[last_w] = 1'b0; end
    rv = '0;
    for (int c = 0; c < 5; c++) step();
    dr = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("t4_pop3", 64'(t_pop[3]), 64'd1);
    chk("t4_prio4", 64'(t_op[4]), 64'd3);
    chk("t4_prio5", 64'(t_op[5]), 64'd7);
    chk("t4_prio6", 64'(t_op[6]), 64'd9);
    chk("t4_valid456", 64'({t_ov[4], t_ov[5], t_ov[6]}), 64'h7);
    for (int c = 8; c < 13; c++) begin
      chk("t5_hold_prio", 64'(t_op[c]), 64'd9);
      chk("t5_hold_valid", 64'(t_ov[c]), 64'd1);
      chk("t5_no_pop", 64'(t_pop[c]), 64'd0);
    end
    chk("t5_pop13", 64'(t_pop[13]), 64'd1);
    chk("t5_prio14", 64'(t_op[14]), 64'd20);
    chk("t5_prio15", 64'(t_op[15]), 64'd21);

    // Reset in the middle of random traffic.
    cap = 8;
    for (int c = 0; c < 40; c++) begin step(); rand_req(); end
    do_reset(3);

    // Long randomized run with varying sorter depth.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) cap = $urandom_range(2, 8);
      step();
      rand_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
